// File: rtl/led_pulse_pkg.sv
// led_pulse_pkg: shared FSM state type and blink-count width for the LED pulse driver
package led_pulse_pkg;
    localparam int BLINK_CNT_W = 4;
    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} led_state_e;
endpackage

// File: rtl/led_phase_timer.sv
// led_phase_timer: phase counter that restarts on load and saturates at its target
module led_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] target_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign expire_o = cnt_q == target_i;
    always_comb cnt_d = load_i ? '0 : (expire_o ? cnt_q : cnt_q + W'(1));
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_pulse_driver.sv
// led_pulse_driver: blinks led_o req_count_i times per accepted request, then pulses done_o.
// Define LED_PULSE_QUEUE_EN to add a one-entry pending request slot for back-to-back requests.
module led_pulse_driver
    import led_pulse_pkg::*;
#(
    parameter int ON_CYCLES  = 2500000,
    parameter int OFF_CYCLES = 2500000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    input  logic [BLINK_CNT_W-1:0] req_count_i,
    output logic                   req_ready_o,
    output logic                   led_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int MAX_C = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int TW = $clog2(MAX_C + 1);
    localparam logic [TW-1:0] ON_T  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_T = TW'(OFF_CYCLES - 1);
    led_state_e             state_q, state_d;
    logic [BLINK_CNT_W-1:0] rem_q, rem_d;
    logic                   led_q;
    logic                   expire;
    logic                   accept;
    assign accept = req_valid_i && req_ready_o;
    assign led_o  = led_q;
    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
`ifdef LED_PULSE_QUEUE_EN
    logic                   pend_vld_q, pend_vld_d;
    logic [BLINK_CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    assign req_ready_o = !pend_vld_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_vld_q <= 1'b0;
            pend_cnt_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end
`else
    assign req_ready_o = state_q == IDLE;
`endif
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
`ifdef LED_PULSE_QUEUE_EN
        pend_vld_d = pend_vld_q;
        pend_cnt_d = pend_cnt_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                state_d = req_count_i != '0 ? ON : DONE;
                rem_d   = req_count_i;
            end
            ON: if (expire) begin
                state_d = OFF;
                rem_d   = rem_q - BLINK_CNT_W'(1);
            end
            OFF: if (expire) state_d = rem_q != '0 ? ON : DONE;
            default: begin
`ifdef LED_PULSE_QUEUE_EN
                // Chain straight into the queued (or same-cycle) request without an IDLE gap
                if (pend_vld_q) begin
                    state_d    = pend_cnt_q != '0 ? ON : DONE;
                    rem_d      = pend_cnt_q;
                    pend_vld_d = 1'b0;
                end else if (accept) begin
                    state_d = req_count_i != '0 ? ON : DONE;
                    rem_d   = req_count_i;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
`ifdef LED_PULSE_QUEUE_EN
        if (accept && (state_q == ON || state_q == OFF)) begin
            pend_vld_d = 1'b1;
            pend_cnt_d = req_count_i;
        end
`endif
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            led_q   <= state_d == ON;
        end
    end
    led_phase_timer #(.W(TW)) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (state_d != state_q),
        .target_i (state_q == ON ? ON_T : OFF_T),
        .expire_o (expire)
    );
endmodule

// File: tb/tb_led_pulse_driver.sv
// tb_led_pulse_driver: directed per-cycle vectors plus a long 15-blink sequence (ON=4, OFF=3)
module tb_led_pulse_driver;
    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       req_valid_i = 1'b0;
    logic [3:0] req_count_i = '0;
    logic       req_ready_o, led_o, busy_o, done_o;
    int         checks = 0;
    int         failures = 0;
`ifdef LED_PULSE_QUEUE_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif
    typedef struct {
        logic       v;
        logic [3:0] c;
        logic       r;
        logic [3:0] exp;
    } vec_t;
    vec_t vq[$];
    always #5 clk = ~clk;
    led_pulse_driver #(.ON_CYCLES(4), .OFF_CYCLES(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_count_i (req_count_i),
        .req_ready_o (req_ready_o),
        .led_o       (led_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );
    task automatic row(input logic v, input logic [3:0] c, input logic r,
                       input logic l, input logic b, input logic d, input logic rd);
        vq.push_back('{v: v, c: c, r: r, exp: {l, b, d, rd}});
    endtask
    initial begin
        int edges, dones, cyc;
        logic prev;
        bit early;
        // reset state, then count=2 with req_count_i wiggled while busy
        row(0, 0, 0, 0, 0, 0, 1);
        row(0, 0, 1, 0, 0, 0, 1);
        row(1, 2, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) row(0, 7, 1, 1, 1, 0, BR);
        for (int k = 5; k <= 7; k++) row(0, 0, 1, 0, 1, 0, BR);
        for (int k = 8; k <= 11; k++) row(0, 9, 1, 1, 1, 0, BR);
        for (int k = 12; k <= 14; k++) row(0, 0, 1, 0, 1, 0, BR);
        row(0, 0, 1, 0, 1, 1, BR);
        row(0, 0, 1, 0, 0, 0, 1);
        // count=0
        row(1, 0, 1, 0, 0, 0, 1);
        row(0, 0, 1, 0, 1, 1, BR);
        row(0, 0, 1, 0, 0, 0, 1);
        // count=3 aborted by reset in cycle 6
        row(1, 3, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) row(0, 0, 1, 1, 1, 0, BR);
        row(0, 0, 1, 0, 1, 0, BR);
        row(0, 0, 0, 0, 1, 0, BR);
        for (int k = 7; k <= 14; k++) row(0, 0, 1, 0, 0, 0, 1);
`ifdef LED_PULSE_QUEUE_EN
        row(1, 1, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 2; k++) row(0, 1, 1, 1, 1, 0, 1);
        row(1, 1, 1, 1, 1, 0, 1);
        row(0, 1, 1, 1, 1, 0, 0);
        for (int k = 5; k <= 7; k++) row(0, 1, 1, 0, 1, 0, 0);
        row(0, 1, 1, 0, 1, 1, 0);
        for (int k = 9; k <= 12; k++) row(0, 1, 1, 1, 1, 0, 1);
        for (int k = 13; k <= 15; k++) row(0, 1, 1, 0, 1, 0, 1);
        row(0, 1, 1, 0, 1, 1, 1);
        row(0, 1, 1, 0, 0, 0, 1);
`else
        row(1, 1, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) row(1, 1, 1, 1, 1, 0, 0);
        for (int k = 5; k <= 7; k++) row(1, 1, 1, 0, 1, 0, 0);
        row(1, 1, 1, 0, 1, 1, 0);
        row(1, 1, 1, 0, 0, 0, 1);
        for (int k = 10; k <= 13; k++) row(0, 1, 1, 1, 1, 0, 0);
        for (int k = 14; k <= 16; k++) row(0, 1, 1, 0, 1, 0, 0);
        row(0, 1, 1, 0, 1, 1, 0);
        row(0, 1, 1, 0, 0, 0, 1);
`endif
        repeat (2) @(posedge clk);
        foreach (vq[i]) begin
            @(negedge clk);
            req_valid_i = vq[i].v;
            req_count_i = vq[i].c;
            rst_ni      = vq[i].r;
            checks++;
            if ({led_o, busy_o, done_o, req_ready_o} !== vq[i].exp) begin
                failures++;
                $display("FAIL row%0d led/busy/done/ready got=%b want=%b", i,
                         {led_o, busy_o, done_o, req_ready_o}, vq[i].exp);
            end
        end
        // count=15: fifteen LED pulses, then a single done
        @(negedge clk);
        req_valid_i = 1'b1;
        req_count_i = 4'd15;
        rst_ni      = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        edges = 0;
        dones = 0;
        early = 1'b0;
        prev  = led_o;
        if (led_o) edges++;
        for (cyc = 0; cyc < 300 && dones == 0; cyc++) begin
            @(negedge clk);
            if (led_o && !prev) edges++;
            if (done_o) begin
                dones++;
                if (edges != 15) early = 1'b1;
            end
            prev = led_o;
        end
        repeat (3) begin
            @(negedge clk);
            if (done_o) dones++;
            if (led_o && !prev) edges++;
            prev = led_o;
        end
        checks++;
        if (edges != 15) begin
            failures++;
            $display("FAIL cnt15_edges got=%0d want=15", edges);
        end
        checks++;
        if (dones != 1 || early) begin
            failures++;
            $display("FAIL cnt15_done got=%0d early=%0b want=1 early=0", dones, early);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_pulse_driver.md
LED_PULSE_DRIVER -- requirements
Module: led_pulse_driver

Interface
REQ-001 Parameter ON_CYCLES, default 2500000, LED-on time per blink in clk_i cycles (50 ms at 50 MHz); legal range 1..2^24-1.
REQ-002 Parameter OFF_CYCLES, default 2500000, LED-off time after each blink in clk_i cycles; legal range 1..2^24-1.
REQ-003 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_ni  input  1  synchronous active-low reset, sampled on rising edge of clk_i.
REQ-005 req_valid_i  input  1  blink request valid.
REQ-006 req_count_i  input  4  number of blinks requested (0..15).
REQ-007 req_ready_o  output  1  request can be accepted this cycle.
REQ-008 led_o  output  1  registered LED drive, active-high.
REQ-009 busy_o  output  1  FSM not in IDLE.
REQ-010 done_o  output  1  one-cycle pulse at the end of a request.

Function
REQ-011 A request is accepted in the cycle where req_valid_i && req_ready_o; req_count_i is captured in that cycle only.
REQ-012 FSM states: IDLE, ON, OFF, DONE.
- IDLE: accept -> ON if count > 0, else DONE.
- ON: after ON_CYCLES cycles -> OFF.
- OFF: after OFF_CYCLES cycles -> ON if blinks remain, else DONE.
- DONE: one cycle -> IDLE.
REQ-013 led_o is 1 exactly in ON: rises one cycle after acceptance, high for exactly ON_CYCLES cycles, low for exactly OFF_CYCLES cycles, repeated count times.
REQ-014 done_o is 1 exactly in DONE; count 0 gives done_o one cycle after acceptance and no LED activity.
REQ-015 busy_o = (state != IDLE); req_ready_o = (state == IDLE) when LED_PULSE_QUEUE_EN is undefined.
REQ-016 Phase counter width is $clog2(max(ON_CYCLES,OFF_CYCLES)+1); it reloads to 0 on every state entry and never wraps.
REQ-017 The remaining-blink counter is 4 bits and decrements on each ON->OFF transition; no underflow is possible.
REQ-018 req_valid_i while not ready is ignored; it has no side effect and no latching.
REQ-019 req_count_i changes outside the accept cycle do not affect the sequence in progress.

Reset
REQ-020 rst_ni low at any rising edge, including mid-blink, forces IDLE and zeroes all counters and the pending slot; led_o=0, busy_o=0, done_o=0, req_ready_o=1 from the following cycle.
REQ-021 No done_o pulse is produced for a request aborted by reset.

Configuration
REQ-022 Macro LED_PULSE_QUEUE_EN defined adds a one-entry pending slot (valid bit + 4-bit count):
- req_ready_o = !pending_valid;
- acceptance while busy fills the slot;
- in DONE with the slot full, the next state is ON (or DONE for count 0) with the slot count, and the slot clears, so there is no IDLE cycle between requests.
REQ-023 Macro undefined: no pending slot logic exists, and behaviour is exactly REQ-015.

Structure
REQ-024 Package led_pulse_pkg holds the state enum typedef (led_state_e) and the blink-count width constant (BLINK_CNT_W = 4).
REQ-025 There is one sub-module, led_phase_timer (load/expire counter parameterised by width), instantiated once; the FSM stays in led_pulse_driver.

Verification
Benches use ON_CYCLES=4 and OFF_CYCLES=3.
REQ-026 Accept count=2 at cycle 0 -> led_o high cycles 1-4 and 8-11, low 5-7 and 12-14; done_o at cycle 15; req_ready_o=1 at cycle 16.
REQ-027 Accept count=0 -> done_o at cycle 1, led_o never high, busy_o high only cycle 1.
REQ-028 rst_ni low at cycle 6 of a count=3 sequence -> cycle 7 led_o=0, busy_o=0, req_ready_o=1, and no done_o thereafter.
REQ-029 Without the macro: req_valid_i held high with count=1 during a busy sequence -> not accepted until IDLE; second sequence led_o rises 2 cycles after first done_o.
REQ-030 With LED_PULSE_QUEUE_EN: accept count=1, then accept count=1 at cycle 3 -> req_ready_o=0 cycles 4-8; second blink led_o high cycles 9-12; done_o at cycles 8 and 16.
REQ-031 count=15 -> exactly 15 rising edges on led_o, then one done_o.
